// File: rtl/ghost_hit_detector_pkg.sv
// Shared game constants: visible area, FSM encoding and per-game defaults.
package ghost_hit_detector_pkg;

    localparam int unsigned MAX_X   = 640;
    localparam int unsigned MAX_Y   = 480;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned LIVES_INIT_DEFAULT    = 3;
    localparam int unsigned INVULN_FRAMES_DEFAULT = 120;
    localparam int unsigned BLINK_BIT_DEFAULT     = 3;

    // Colour key the sprite ROMs treat as see-through when forming ghost_top_on.
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_INVULN    = 2'd1,
        ST_GAME_OVER = 2'd2
    } game_state_e;

endpackage

// File: rtl/ghost_hit_detector_frame_tick_gen.sv
// One-clock pulse on entry to vertical blanking, independent of pixel-clock ratio.
module ghost_hit_detector_frame_tick_gen
    import ghost_hit_detector_pkg::*;
#(
    parameter int unsigned BLANK_Y = MAX_Y
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] y_i,
    output logic               frame_tick_c_o
);

    logic vb;
    logic vb_q;

    assign vb = (y_i >= COORD_W'(BLANK_Y));

    // Resets high so releasing reset inside blanking cannot fake a frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_q <= 1'b1;
        end else begin
            vb_q <= vb;
        end
    end

    assign frame_tick_c_o = vb & ~vb_q;

endmodule

// File: rtl/ghost_hit_detector.sv
// Per-frame ghost/player collision detection with lives, invulnerability blink and game-over.
module ghost_hit_detector
    import ghost_hit_detector_pkg::*;
#(
    parameter int unsigned LIVES_INIT    = LIVES_INIT_DEFAULT,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEFAULT,
    parameter int unsigned BLINK_BIT     = BLINK_BIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               ghost_top_on,
    input  logic               yoshi_on,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               hit,
    output logic               invuln,
    output logic               yoshi_visible,
    output logic               game_over
);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               hit_q, hit_d;
    logic               invuln_q, invuln_d;
    logic               vis_q, vis_d;
    logic               go_q, go_d;
    logic               frame_tick;
    logic               overlap;

    ghost_hit_detector_frame_tick_gen #(
        .BLANK_Y (MAX_Y)
    ) u_tick (
        .clk            (clk),
        .rst_n          (reset),
        .y_i            (y),
        .frame_tick_c_o (frame_tick)
    );

    assign overlap = ghost_top_on & yoshi_on
                   & (x < COORD_W'(MAX_X)) & (y < COORD_W'(MAX_Y));

    // Sticky overlap flag; the tick cycle reads it before it is cleared.
    assign acc_d = (restart | frame_tick) ? 1'b0 : (acc_q | overlap);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        if (restart) begin
            state_d = ST_ALIVE;
            lives_d = LIVES_W'(LIVES_INIT);
            cnt_d   = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (acc_q) begin
                        hit_d = 1'b1;
                        if (lives_q <= LIVES_W'(1)) begin
                            state_d = ST_GAME_OVER;
                            lives_d = '0;
                        end else begin
                            state_d = ST_INVULN;
                            lives_d = lives_q - LIVES_W'(1);
                            cnt_d   = CNT_W'(INVULN_FRAMES);
                        end
                    end
                end
                ST_INVULN: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                    lives_d = '0;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end

        invuln_d = (state_d == ST_INVULN);
        go_d     = (state_d == ST_GAME_OVER);
        vis_d    = (state_d == ST_INVULN) ? ~cnt_d[BLINK_BIT] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ALIVE;
            lives_q  <= LIVES_W'(LIVES_INIT);
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            hit_q    <= 1'b0;
            invuln_q <= 1'b0;
            vis_q    <= 1'b1;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            hit_q    <= hit_d;
            invuln_q <= invuln_d;
            vis_q    <= vis_d;
            go_q     <= go_d;
        end
    end

    assign lives         = lives_q;
    assign hit           = hit_q;
    assign invuln        = invuln_q;
    assign yoshi_visible = vis_q;
    assign game_over     = go_q;

endmodule

// File: tb/tb_ghost_hit_detector.sv
// Scoreboard bench: stimulus queues expected status per frame tick / restart, monitor compares.
module tb_ghost_hit_detector;

    logic       clk;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic       ghost_top_on;
    logic       yoshi_on;
    logic       restart;
    logic [2:0] lives;
    logic       hit;
    logic       invuln;
    logic       yoshi_visible;
    logic       game_over;

    typedef struct {
        string      tag;
        logic       hit;
        logic [2:0] lives;
        logic       inv;
        logic       vis;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    logic vbp;

    ghost_hit_detector dut (
        .clk           (clk),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .ghost_top_on  (ghost_top_on),
        .yoshi_on      (yoshi_on),
        .restart       (restart),
        .lives         (lives),
        .hit           (hit),
        .invuln        (invuln),
        .yoshi_visible (yoshi_visible),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string tag, input logic h, input logic [2:0] l,
                                input logic i, input logic v, input logic g);
        exp_t e;
        e.tag = tag; e.hit = h; e.lives = l; e.inv = i; e.vis = v; e.go = g;
        return e;
    endfunction

    task automatic check(input exp_t e);
        tests++;
        if ({hit, lives, invuln, yoshi_visible, game_over} !== {e.hit, e.lives, e.inv, e.vis, e.go}) begin
            fails++;
            $display("FAIL %s: got hit=%0b lives=%0d invuln=%0b vis=%0b go=%0b, want hit=%0b lives=%0d invuln=%0b vis=%0b go=%0b",
                     e.tag, hit, lives, invuln, yoshi_visible, game_over,
                     e.hit, e.lives, e.inv, e.vis, e.go);
        end
    endtask

    // Monitor: mirrors the blanking edge from y and checks outputs after each tick or restart edge.
    initial begin
        logic tk;
        logic rs;
        logic rn;
        vbp = 1'b1;
        forever begin
            @(posedge clk);
            rn  = reset;
            tk  = rn && (y >= 10'd480) && !vbp;
            vbp = !rn ? 1'b1 : (y >= 10'd480);
            rs  = restart;
            #1;
            if (rn && (tk || rs)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got an update event, want a queued expectation");
                end else begin
                    check(exp_q.pop_front());
                end
            end else if (rn) begin
                tests++;
                if (hit !== 1'b0) begin
                    fails++;
                    $display("FAIL hit_pulse: got hit=%0b outside a tick cycle, want 0", hit);
                end
            end
        end
    end

    task automatic drive(input logic [9:0] px, input logic [9:0] py,
                         input logic g, input logic yo, input logic rs);
        @(negedge clk);
        x = px; y = py; ghost_top_on = g; yoshi_on = yo; restart = rs;
    endtask

    // One compressed frame: a single pixel, then blanking (optionally with restart on the tick).
    task automatic frame(input logic [9:0] px, input logic [9:0] py, input logic g,
                         input logic yo, input logic rs_tick, input exp_t e);
        exp_q.push_back(e);
        drive(px, py, g, yo, 1'b0);
        drive(10'd0, 10'd480, 1'b0, 1'b0, rs_tick);
        drive(10'd0, 10'd490, 1'b0, 1'b0, 1'b0);
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic invuln_window(input logic [2:0] l, input string tag);
        logic [7:0] c;
        for (int k = 1; k <= 120; k++) begin
            c = 8'(120 - k);
            if (k < 120) frame(10'd100, 10'd100, 1'b1, 1'b1, 1'b0, mk(tag, 1'b0, l, 1'b1, ~c[3], 1'b0));
            else         frame(10'd100, 10'd100, 1'b1, 1'b1, 1'b0, mk({tag, "_end"}, 1'b0, l, 1'b0, 1'b1, 1'b0));
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; x = 10'd0; y = 10'd200;
        ghost_top_on = 1'b0; yoshi_on = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check(mk("reset_state", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));

        frame(10'd50, 10'd50, 1'b0, 1'b0, 1'b0, mk("quiet_frame", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
        frame(10'd100, 10'd100, 1'b1, 1'b1, 1'b0, mk("hit1", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0));
        invuln_window(3'd2, "inv1");
        frame(10'd639, 10'd479, 1'b1, 1'b1, 1'b0, mk("hit2_corner", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
        invuln_window(3'd1, "inv2");
        frame(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, mk("hit3_fatal", 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
        frame(10'd100, 10'd100, 1'b1, 1'b1, 1'b0, mk("go_overlap_a", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1));
        frame(10'd200, 10'd300, 1'b1, 1'b1, 1'b0, mk("go_overlap_b", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1));

        frame(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, mk("restart_on_tick", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
        frame(10'd10, 10'd10, 1'b0, 1'b0, 1'b0, mk("after_restart", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));

        frame(10'd640, 10'd100, 1'b1, 1'b1, 1'b0, mk("edge_x640", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
        frame(10'd100, 10'd480, 1'b1, 1'b1, 1'b0, mk("edge_y480", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));

        exp_q.push_back(mk("ghost_only", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 20; i++) drive(10'(i * 31), 10'(i * 23), 1'b1, 1'b0, 1'b0);
        drive(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        frame(10'd300, 10'd200, 1'b1, 1'b1, 1'b0, mk("hit_again", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk("restart_in_invuln", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
        drive(10'd5, 10'd5, 1'b0, 1'b0, 1'b1);
        drive(10'd6, 10'd5, 1'b0, 1'b0, 1'b0);
        frame(10'd7, 10'd7, 1'b0, 1'b0, 1'b0, mk("alive_after_restart", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));

        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
